// File: rtl/seq_btn_input_pkg.sv
// Shared constants for the sequence-analyzer button front end and its downstream shift-register stage.
package seq_pkg;

  localparam int N_BTN     = 4;
  localparam int SEQ_W     = 4;
  localparam int DEB_CNT_W = 8;
  localparam int REP_CNT_W = 10;

  localparam int DEF_CNT_WDT = 16;
  localparam int DEF_DIV_VAL = 48000;
  localparam int DEF_DEB_MS  = 20;
  localparam int DEF_REP_DLY = 500;
  localparam int DEF_REP_PER = 100;

  typedef logic [N_BTN-1:0] btn_vec_t;
  typedef logic [SEQ_W-1:0] seq_code_t;

endpackage

// File: rtl/seq_btn_input_if.sv
// Button/strobe bundle between the raw button source and the debounced press stage.
interface seq_btn_input_if;
  import seq_pkg::*;

  btn_vec_t  BTN;
  logic      CE_1K;
  btn_vec_t  BTN_STATE;
  seq_code_t SEQ;
  logic      BTN_OR;

  modport master (output BTN, input CE_1K, BTN_STATE, SEQ, BTN_OR);
  modport slave  (input BTN, output CE_1K, BTN_STATE, SEQ, BTN_OR);
endinterface

// File: rtl/seq_btn_input_btn_debounce.sv
// One button channel: 2-FF synchroniser, tick-driven debounce counter, stable level and rise flag.
module btn_debounce
  import seq_pkg::*;
#(
  parameter int DEB_MS = DEF_DEB_MS
) (
  input  logic CLK_48,
  input  logic SYS_NRST,
  input  logic i_btn,
  input  logic i_ce,
  output logic o_state,
  output logic o_state_nxt,
  output logic o_rise
);

  logic [1:0]           r_sync;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic                 r_state;
  logic                 w_btn_s;
  logic                 w_accept;

  assign w_btn_s  = r_sync[1];
  assign w_accept = i_ce && (w_btn_s != r_state) && (r_cnt == DEB_CNT_W'(DEB_MS - 1));

  // Any sampled agreement with the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (i_ce) begin
        if (w_btn_s == r_state) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_state <= w_btn_s;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_state     = r_state;
  assign o_state_nxt = w_accept ? w_btn_s : r_state;
  assign o_rise      = w_accept && w_btn_s;

endmodule

// File: rtl/seq_btn_input.sv
// Button input stage: 1 kHz prescaler, N_BTN debounce channels, press strobe and SEQ latch.
// Optional auto-repeat of the held code is built when SEQ_BTN_AUTO_REPEAT_EN is defined.
module seq_btn_input
  import seq_pkg::*;
#(
  parameter int CNT_WDT = DEF_CNT_WDT,
  parameter int DIV_VAL = DEF_DIV_VAL,
  parameter int DEB_MS  = DEF_DEB_MS,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input logic             CLK_48,
  input logic             SYS_NRST,
  seq_btn_input_if.slave  bus
);

  logic [CNT_WDT-1:0] r_presc;
  logic               r_ce;
  logic               w_wrap;
  btn_vec_t           w_state;
  btn_vec_t           w_state_nxt;
  btn_vec_t           w_rise;
  logic               w_rep;
  logic               w_strobe;
  logic               r_btn_or;
  seq_code_t          r_seq;

  assign w_wrap = (r_presc == CNT_WDT'(DIV_VAL - 1));

  // CE_1K is registered off the wrap, so the first tick lands DIV_VAL clocks after reset.
  always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_presc <= '0;
      r_ce    <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      r_ce    <= w_wrap;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce #(.DEB_MS(DEB_MS)) u_deb (
      .CLK_48      (CLK_48),
      .SYS_NRST    (SYS_NRST),
      .i_btn       (bus.BTN[i]),
      .i_ce        (r_ce),
      .o_state     (w_state[i]),
      .o_state_nxt (w_state_nxt[i]),
      .o_rise      (w_rise[i])
    );
  end

`ifdef SEQ_BTN_AUTO_REPEAT_EN
  logic [REP_CNT_W-1:0] r_hold;
  logic                 r_rep_armed;
  logic                 w_change;

  assign w_change = (w_state_nxt != w_state);
  assign w_rep    = r_ce && !w_change && (w_state != '0) &&
                    (r_hold == (r_rep_armed ? REP_CNT_W'(REP_PER - 1) : REP_CNT_W'(REP_DLY - 1)));

  // Hold counter restarts on every level change; after the first repeat it switches to the short period.
  always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_hold      <= '0;
      r_rep_armed <= 1'b0;
    end else if (r_ce) begin
      if (w_change || (w_state == '0)) begin
        r_hold      <= '0;
        r_rep_armed <= 1'b0;
      end else if (w_rep) begin
        r_hold      <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  assign w_strobe = (|w_rise) || w_rep;

  // SEQ captures the post-update levels so chords and held-plus-new presses show every set bit.
  always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_btn_or <= 1'b0;
      r_seq    <= '0;
    end else begin
      r_btn_or <= w_strobe;
      if (w_strobe) r_seq <= w_state_nxt;
    end
  end

  assign bus.CE_1K     = r_ce;
  assign bus.BTN_STATE = w_state;
  assign bus.SEQ       = r_seq;
  assign bus.BTN_OR    = r_btn_or;

endmodule

// File: tb/tb_seq_btn_input.sv
// Directed bench for seq_btn_input with a strobe scoreboard; expects DIV_VAL=10, DEB_MS=4, REP_DLY=6, REP_PER=3.
module tb_seq_btn_input;
  import seq_pkg::*;

  typedef struct {
    logic [3:0] seq;
    int         cyc;
  } exp_t;

  logic            CLK_48 = 1'b0;
  logic            SYS_NRST;
  int              cyc;
  int              compared = 0;
  int              mismatched = 0;
  exp_t            q[$];
  seq_btn_input_if bus();

  seq_btn_input #(
    .CNT_WDT (16),
    .DIV_VAL (10),
    .DEB_MS  (4),
    .REP_DLY (6),
    .REP_PER (3)
  ) dut (
    .CLK_48   (CLK_48),
    .SYS_NRST (SYS_NRST),
    .bus      (bus)
  );

  always #5 CLK_48 = ~CLK_48;

  // Reference clock count since reset release; tick k is visible at cyc == 10*k.
  always @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCyc(input int t);
    int guard = 0;
    while (cyc != t && guard < 2000) begin
      @(negedge CLK_48);
      guard++;
    end
    if (cyc != t) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_timeout: reached cyc %0d, expected %0d", cyc, t);
    end
  endtask

  task automatic applyStimulus(input int t, input logic [3:0] btn);
    waitCyc(t);
    bus.BTN = btn;
  endtask

  task automatic pushStrobe(input logic [3:0] seq, input int at);
    exp_t e;
    e.seq = seq;
    e.cyc = at;
    q.push_back(e);
  endtask

  always @(negedge CLK_48) begin
    if (SYS_NRST) begin
      checkOutput("ce_1k", 32'(bus.CE_1K), 32'((cyc > 0) && (cyc % 10 == 0)));
      if (bus.BTN_OR) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_strobe: BTN_OR=1 at cyc %0d with SEQ=%0h, none expected", cyc, bus.SEQ);
        end else begin
          exp_t e;
          e = q.pop_front();
          checkOutput("strobe_cyc", 32'(cyc), 32'(e.cyc));
          checkOutput("strobe_seq", 32'(bus.SEQ), 32'(e.seq));
        end
      end
    end
  end

  initial begin
    SYS_NRST = 1'b0;
    bus.BTN  = 4'h0;
    repeat (5) @(negedge CLK_48);
    checkOutput("rst_state", 32'(bus.BTN_STATE), 32'h0);
    checkOutput("rst_seq", 32'(bus.SEQ), 32'h0);
    checkOutput("rst_or", 32'(bus.BTN_OR), 32'h0);
    checkOutput("rst_ce", 32'(bus.CE_1K), 32'h0);
    SYS_NRST = 1'b1;

    // Clean press of bit 1, then release
    applyStimulus(1, 4'b0010);
    checkOutput("idle_state", 32'(bus.BTN_STATE), 32'h0);
    checkOutput("idle_seq", 32'(bus.SEQ), 32'h0);
    pushStrobe(4'h2, 41);
    waitCyc(31);
    checkOutput("press_pre_state", 32'(bus.BTN_STATE), 32'h0);
    waitCyc(41);
    checkOutput("press_state", 32'(bus.BTN_STATE), 32'h2);
    applyStimulus(45, 4'b0000);
    waitCyc(81);
    checkOutput("release_state", 32'(bus.BTN_STATE), 32'h0);
    checkOutput("release_seq", 32'(bus.SEQ), 32'h2);

    // Bounce on bit 0: three high ticks, one low tick, then steady high
    applyStimulus(85, 4'b0001);
    applyStimulus(111, 4'b0000);
    waitCyc(121);
    checkOutput("bounce_state_a", 32'(bus.BTN_STATE), 32'h0);
    bus.BTN = 4'b0001;
    pushStrobe(4'h1, 161);
    waitCyc(151);
    checkOutput("bounce_state_b", 32'(bus.BTN_STATE), 32'h0);
    waitCyc(161);
    checkOutput("bounce_state_c", 32'(bus.BTN_STATE), 32'h1);
    applyStimulus(165, 4'b0000);
    waitCyc(201);
    checkOutput("bounce_rel_state", 32'(bus.BTN_STATE), 32'h0);

    // Chord 1001, then bit 2 added while held
    applyStimulus(205, 4'b1001);
    pushStrobe(4'h9, 241);
    applyStimulus(245, 4'b1101);
    pushStrobe(4'hD, 281);
    applyStimulus(285, 4'b0000);
    waitCyc(321);
    checkOutput("chord_rel_state", 32'(bus.BTN_STATE), 32'h0);
    checkOutput("chord_rel_seq", 32'(bus.SEQ), 32'hD);

    // Long hold of bit 3
    applyStimulus(325, 4'b1000);
    pushStrobe(4'h8, 361);
`ifdef SEQ_BTN_AUTO_REPEAT_EN
    pushStrobe(4'h8, 421);
    pushStrobe(4'h8, 451);
    pushStrobe(4'h8, 481);
    pushStrobe(4'h8, 511);
`endif
    applyStimulus(485, 4'b0000);
    waitCyc(521);
    checkOutput("hold_rel_state", 32'(bus.BTN_STATE), 32'h0);
    checkOutput("hold_rel_seq", 32'(bus.SEQ), 32'h8);

    // Reset two ticks into a press of bit 2; the press restarts from scratch
    applyStimulus(525, 4'b0100);
    waitCyc(545);
    SYS_NRST = 1'b0;
    #1;
    checkOutput("midrst_state", 32'(bus.BTN_STATE), 32'h0);
    checkOutput("midrst_seq", 32'(bus.SEQ), 32'h0);
    checkOutput("midrst_or", 32'(bus.BTN_OR), 32'h0);
    repeat (3) @(negedge CLK_48);
    SYS_NRST = 1'b1;
    pushStrobe(4'h4, 41);
    waitCyc(31);
    checkOutput("midrst_pre_state", 32'(bus.BTN_STATE), 32'h0);
    waitCyc(41);
    checkOutput("midrst_press_state", 32'(bus.BTN_STATE), 32'h4);
    waitCyc(60);
    checkOutput("pending_strobes", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
